// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock, start/done handshake.
// Optional build macro LEADING_ZERO_BLANK_EN: leading zero digits are loaded as 4'hF (blank).
module bin2bcd_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] number,
  output logic             busy,
  output logic             done,
  output logic [3:0]       thousands,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        digits_q, digits_d;
  logic               done_q, done_d;

  // Add-3 on every field >= 5. Bit 15 of the result would be shifted out, so only 15 bits are kept.
  function automatic logic [14:0] add3_fields(input logic [15:0] b);
    logic [2:0] f3;
    logic [3:0] f2, f1, f0;
    f3 = (b[15:12] >= 4'd5) ? (b[14:12] + 3'd3) : b[14:12];
    f2 = (b[11:8]  >= 4'd5) ? (b[11:8]  + 4'd3) : b[11:8];
    f1 = (b[7:4]   >= 4'd5) ? (b[7:4]   + 4'd3) : b[7:4];
    f0 = (b[3:0]   >= 4'd5) ? (b[3:0]   + 4'd3) : b[3:0];
    return {f3, f2, f1, f0};
  endfunction

  function automatic logic [15:0] blank_leading(input logic [15:0] d);
    logic [15:0] r;
    r = d;
`ifdef LEADING_ZERO_BLANK_EN
    if (r[15:12] == 4'h0) begin
      r[15:12] = 4'hF;
      if (r[11:8] == 4'h0) begin
        r[11:8] = 4'hF;
        if (r[7:4] == 4'h0) r[7:4] = 4'hF;
      end
    end
`endif
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, one add-3-then-shift per SHIFT cycle, publish digits in DONE.
  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d = number;
          bcd_d = '0;
          cnt_d = CNT_W'(WIDTH);
        end
      end
      SHIFT: begin
        bcd_d = {add3_fields(bcd_q), bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
      end
      DONE: begin
        digits_d = blank_leading(bcd_q);
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = done_q;
    thousands = digits_q[15:12];
    hundreds  = digits_q[11:8];
    tens      = digits_q[7:4];
    ones      = digits_q[3:0];
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq (WIDTH=8): latency, digits, ignored starts, abort, streaming.
module tb_bin2bcd_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] number = '0;
  logic       busy, done;
  logic [3:0] thousands, hundreds, tens, ones;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bin2bcd_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .number(number),
    .busy(busy), .done(done),
    .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Plain BCD expectation, with leading zeros blanked in the blanking build.
  function automatic logic [15:0] exp_digits(input logic [15:0] d);
    logic [15:0] r;
    r = d;
`ifdef LEADING_ZERO_BLANK_EN
    if (r[15:12] == 4'h0) begin
      r[15:12] = 4'hF;
      if (r[11:8] == 4'h0) begin
        r[11:8] = 4'hF;
        if (r[7:4] == 4'h0) r[7:4] = 4'hF;
      end
    end
`endif
    return r;
  endfunction

  function automatic logic [15:0] digits();
    return {thousands, hundreds, tens, ones};
  endfunction

  task automatic run_conv(input string tag, input logic [7:0] n, input logic [15:0] bcd);
    int  busy_cnt;
    bit  seen;
    @(negedge clk);
    start  = 1'b1;
    number = n;
    @(posedge clk);
    #1 start = 1'b0;
    number = 8'hA5;
    busy_cnt = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) busy_cnt++;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy_cycles"}, busy_cnt, 9);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_digits"}, digits(), exp_digits(bcd));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_digits_hold"}, digits(), exp_digits(bcd));
  endtask

  initial begin
    int dones;
    int last_cyc;
    logic [15:0] bcd_exp;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_digits", digits(), 16'h0000);
    rst = 1'b0;

    run_conv("n255", 8'd255, 16'h0255);
    run_conv("n225", 8'd225, 16'h0225);
    run_conv("n0",   8'd0,   16'h0000);
    run_conv("n99",  8'd99,  16'h0099);

    // Reset pulse while idle clears published digits.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("idle_rst_digits", digits(), 16'h0000);
    check("idle_rst_busy", busy, 0);
    check("idle_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Second start during SHIFT is ignored.
    @(negedge clk);
    start = 1'b1; number = 8'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; number = 8'd99;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        check("ignore_digits", digits(), exp_digits(16'h0007));
      end
    end
    check("ignore_done_count", dones, 1);

    // Abort mid-conversion.
    @(negedge clk);
    start = 1'b1; number = 8'd200;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_digits", digits(), 16'h0000);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_conv("n200", 8'd200, 16'h0200);

    // Start held high: back-to-back conversions, alternating operands.
    @(negedge clk);
    start = 1'b1; number = 8'd10;
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      check("stream_done_seen", seen, 1);
      bcd_exp = (k % 2 == 0) ? 16'h0010 : 16'h0100;
      check("stream_digits", digits(), exp_digits(bcd_exp));
      if (k > 0) check("stream_period", cyc - last_cyc, 10);
      last_cyc = cyc;
      number = (k % 2 == 0) ? 8'd100 : 8'd10;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
